// File: rtl/operand_fetch_if.sv
// operand_fetch_if
//   Bundles every non-clock signal of the operand-fetch stage: decoded
//   instruction handshake, register-file read data, writeback port and the
//   operand bundle handed to execute.
//   master : decode / register file / writeback / execute side
//   slave  : the operand_fetch stage itself
interface operand_fetch_if;
    // Decoded instruction from decode
    logic        w_in_valid;
    logic        w_in_ready;
    logic [4:0]  w_address_s1_5;
    logic [4:0]  w_address_s2_5;
    logic [4:0]  w_address_d_5;
    logic        w_in_is_load;
    logic [31:0] w_in_imm_32;
    // Combinational register-file read data (addressed by w_address_s*_5)
    logic [31:0] w_rf_s1val_32;
    logic [31:0] w_rf_s2val_32;
    // Writeback port (also the register-file write port)
    logic        w_wb_en;
    logic [4:0]  w_wb_address_5;
    logic [31:0] w_wb_data_32;
    // Operand bundle to execute
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_s1val_32;
    logic [31:0] w_out_s2val_32;
    logic [31:0] w_out_imm_32;
    logic [4:0]  w_out_address_d_5;
    logic        w_out_is_load;
    // Saturating stall-cycle counter
    logic [15:0] w_stall_count_16;

    modport master (
        output w_in_valid, w_address_s1_5, w_address_s2_5, w_address_d_5,
               w_in_is_load, w_in_imm_32, w_rf_s1val_32, w_rf_s2val_32,
               w_wb_en, w_wb_address_5, w_wb_data_32, w_out_ready,
        input  w_in_ready, w_out_valid, w_out_s1val_32, w_out_s2val_32,
               w_out_imm_32, w_out_address_d_5, w_out_is_load, w_stall_count_16
    );

    modport slave (
        input  w_in_valid, w_address_s1_5, w_address_s2_5, w_address_d_5,
               w_in_is_load, w_in_imm_32, w_rf_s1val_32, w_rf_s2val_32,
               w_wb_en, w_wb_address_5, w_wb_data_32, w_out_ready,
        output w_in_ready, w_out_valid, w_out_s1val_32, w_out_s2val_32,
               w_out_imm_32, w_out_address_d_5, w_out_is_load, w_stall_count_16
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch
//   Pipeline stage between decode and execute. Reads both source operands
//   (register 0 always reads as zero), registers them together with the
//   immediate, destination and load flag, and hands the bundle to execute
//   with a valid/ready handshake. A load followed by a dependent instruction
//   costs one LOAD_BUBBLE cycle after the load leaves the stage.
//
//   Build option OPFETCH_WB_BYPASS_EN:
//     defined   - a source hitting the active writeback register takes the
//                 writeback data directly, no stall.
//     undefined - the same hit stalls for one WB_WAIT cycle and the updated
//                 register-file value is read afterwards.
//
// Ports
//   clock : pipeline clock, rising edge
//   reset : asynchronous, active-high
//   bus   : operand_fetch_if.slave (instruction in, register file, writeback,
//           operand bundle out, stall counter)
module operand_fetch (
    input  logic           clock,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        RUN         = 2'b00,
        LOAD_BUBBLE = 2'b01,
        WB_WAIT     = 2'b10
    } state_t;

    // A source depends on a register only when it names it and is not r0.
    function automatic logic src_match(input logic [4:0] src, input logic [4:0] reg_num);
        return (src != 5'd0) && (src == reg_num);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic        out_valid_r;
    logic [31:0] out_s1val_r;
    logic [31:0] out_s2val_r;
    logic [31:0] out_imm_r;
    logic [4:0]  out_address_d_r;
    logic        out_is_load_r;
    logic [15:0] stall_count_r;

    logic        load_use_s;
    logic        hazard_s;
    logic        in_ready_s;
    logic        xfer_in_s;
    logic        xfer_out_s;
    logic        stall_s;
    logic        bubble_req_s;
    logic [31:0] s1_operand_s;
    logic [31:0] s2_operand_s;
`ifndef OPFETCH_WB_BYPASS_EN
    logic        wb_match_s;
`endif

    // Hazard detection, handshake qualification and operand selection
    always_comb begin
        load_use_s = out_valid_r && out_is_load_r &&
                     (src_match(bus.w_address_s1_5, out_address_d_r) ||
                      src_match(bus.w_address_s2_5, out_address_d_r));
`ifdef OPFETCH_WB_BYPASS_EN
        hazard_s = load_use_s;
`else
        // Without the bypass the register file still holds the old value this
        // cycle, so the instruction must wait for the write to land.
        wb_match_s = bus.w_wb_en &&
                     (src_match(bus.w_address_s1_5, bus.w_wb_address_5) ||
                      src_match(bus.w_address_s2_5, bus.w_wb_address_5));
        hazard_s = load_use_s || wb_match_s;
`endif
        in_ready_s = !reset && (!out_valid_r || bus.w_out_ready) && !hazard_s &&
                     (state_r == RUN);
        xfer_in_s  = bus.w_in_valid && in_ready_s;
        xfer_out_s = out_valid_r && bus.w_out_ready;
        stall_s    = bus.w_in_valid && !in_ready_s;
        // The load leaves while its consumer is waiting: insert one bubble.
        bubble_req_s = bus.w_in_valid && load_use_s && bus.w_out_ready;

        if (bus.w_address_s1_5 == 5'd0) begin
            s1_operand_s = 32'd0;
        end
`ifdef OPFETCH_WB_BYPASS_EN
        else if (bus.w_wb_en && (bus.w_wb_address_5 == bus.w_address_s1_5)) begin
            s1_operand_s = bus.w_wb_data_32;
        end
`endif
        else begin
            s1_operand_s = bus.w_rf_s1val_32;
        end

        if (bus.w_address_s2_5 == 5'd0) begin
            s2_operand_s = 32'd0;
        end
`ifdef OPFETCH_WB_BYPASS_EN
        else if (bus.w_wb_en && (bus.w_wb_address_5 == bus.w_address_s2_5)) begin
            s2_operand_s = bus.w_wb_data_32;
        end
`endif
        else begin
            s2_operand_s = bus.w_rf_s2val_32;
        end
    end

    // Next-state logic; bubble and writeback wait each last one cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (bubble_req_s) begin
                    state_next_s = LOAD_BUBBLE;
                end
`ifndef OPFETCH_WB_BYPASS_EN
                else if (bus.w_in_valid && wb_match_s) begin
                    state_next_s = WB_WAIT;
                end
`endif
                else begin
                    state_next_s = RUN;
                end
            end
            LOAD_BUBBLE: state_next_s = RUN;
            WB_WAIT:     state_next_s = RUN;
            default:     state_next_s = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand bundle register: loads on transfer in, holds otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r     <= 1'b0;
            out_s1val_r     <= 32'd0;
            out_s2val_r     <= 32'd0;
            out_imm_r       <= 32'd0;
            out_address_d_r <= 5'd0;
            out_is_load_r   <= 1'b0;
        end else begin
            if (xfer_in_s) begin
                out_valid_r     <= 1'b1;
                out_s1val_r     <= s1_operand_s;
                out_s2val_r     <= s2_operand_s;
                out_imm_r       <= bus.w_in_imm_32;
                out_address_d_r <= bus.w_address_d_5;
                out_is_load_r   <= bus.w_in_is_load;
            end else if (xfer_out_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_r <= 16'd0;
        end else if (stall_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end
    end

    assign bus.w_in_ready        = in_ready_s;
    assign bus.w_out_valid       = out_valid_r;
    assign bus.w_out_s1val_32    = out_s1val_r;
    assign bus.w_out_s2val_32    = out_s2val_r;
    assign bus.w_out_imm_32      = out_imm_r;
    assign bus.w_out_address_d_5 = out_address_d_r;
    assign bus.w_out_is_load     = out_is_load_r;
    assign bus.w_stall_count_16  = stall_count_r;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Directed bench for operand_fetch with a register-file model and a
//   scoreboard of expected operand bundles (pushed on transfer in, popped on
//   transfer out). Works for both settings of OPFETCH_WB_BYPASS_EN.
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] s1val;
        logic [31:0] s2val;
        logic [31:0] imm;
        logic [4:0]  d;
        logic        is_load;
    } bundle_t;

    logic clock;
    logic reset;
    operand_fetch_if bus();

    logic [31:0] rf [32];
    bundle_t     sb [$];
    int          total;
    int          bad;
    logic [15:0] exp_stall;

    operand_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.w_rf_s1val_32 = rf[bus.w_address_s1_5];
    assign bus.w_rf_s2val_32 = rf[bus.w_address_s2_5];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog expired total=%0d bad=%0d", total, bad);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input bundle_t obs, input bundle_t exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_operand(input logic [4:0] a);
        logic [31:0] v;
        v = rf[a];
        if (a == 5'd0) v = 32'd0;
`ifdef OPFETCH_WB_BYPASS_EN
        else if (bus.w_wb_en && (bus.w_wb_address_5 == a)) v = bus.w_wb_data_32;
`endif
        return v;
    endfunction

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic ld, input logic [31:0] imm);
        bus.w_in_valid     = 1'b1;
        bus.w_address_s1_5 = s1;
        bus.w_address_s2_5 = s2;
        bus.w_address_d_5  = d;
        bus.w_in_is_load   = ld;
        bus.w_in_imm_32    = imm;
    endtask

    task automatic idle();
        bus.w_in_valid = 1'b0;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] data);
        bus.w_wb_en        = en;
        bus.w_wb_address_5 = a;
        bus.w_wb_data_32   = data;
    endtask

    // One clock: scoreboard at mid-cycle, then edge, then register-file write.
    task automatic tick();
        bundle_t e;
        bundle_t o;
        @(negedge clock);
        if (bus.w_in_valid && bus.w_in_ready) begin
            e.s1val   = exp_operand(bus.w_address_s1_5);
            e.s2val   = exp_operand(bus.w_address_s2_5);
            e.imm     = bus.w_in_imm_32;
            e.d       = bus.w_address_d_5;
            e.is_load = bus.w_in_is_load;
            sb.push_back(e);
        end
        if (bus.w_out_valid && bus.w_out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                o = {bus.w_out_s1val_32, bus.w_out_s2val_32, bus.w_out_imm_32,
                     bus.w_out_address_d_5, bus.w_out_is_load};
                check_bundle("bundle", o, e);
            end
        end
        @(posedge clock);
        #1;
        if (bus.w_wb_en) rf[bus.w_wb_address_5] = bus.w_wb_data_32;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_stall = 16'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        rf[0] = 32'hBAD0_0000;
        reset = 1'b1;
        idle();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        idle();
        set_wb(1'b0, 5'd0, 32'd0);
        bus.w_out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(bus.w_out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.w_in_ready), 32'd0);
        check("rst_stall", 32'(bus.w_stall_count_16), 32'd0);
        check("rst_s1val", bus.w_out_s1val_32, 32'd0);
        check("rst_is_load", 32'(bus.w_out_is_load), 32'd0);
        #10;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Plain issue
        bus.w_out_ready = 1'b1;
        issue(5'd5, 5'd6, 5'd7, 1'b0, 32'h0000_0011);
        #1;
        check("plain_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        check("plain_valid", 32'(bus.w_out_valid), 32'd1);
        check("plain_s1val", bus.w_out_s1val_32, 32'd5);
        check("plain_s2val", bus.w_out_s2val_32, 32'd6);
        check("plain_d", 32'(bus.w_out_address_d_5), 32'd7);
        check("plain_stall", 32'(bus.w_stall_count_16), 32'd0);
        idle();
        tick();
        check("plain_drain", 32'(bus.w_out_valid), 32'd0);

        // Load-use: one hazard cycle plus one bubble cycle
        issue(5'd1, 5'd2, 5'd8, 1'b1, 32'h0000_0020);
        #1;
        tick();
        issue(5'd8, 5'd3, 5'd9, 1'b0, 32'h0000_0021);
        #1;
        check("lu_hazard_ready", 32'(bus.w_in_ready), 32'd0);
        tick();
        check("lu_load_gone", 32'(bus.w_out_valid), 32'd0);
        #1;
        check("lu_bubble_ready", 32'(bus.w_in_ready), 32'd0);
        tick();
        #1;
        check("lu_after_bubble_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        exp_stall = 16'd2;
        check("lu_valid", 32'(bus.w_out_valid), 32'd1);
        check("lu_s1val", bus.w_out_s1val_32, 32'd8);
        check("lu_stall", 32'(bus.w_stall_count_16), 32'(exp_stall));
        idle();
        tick();

        // Writeback to a source register
        issue(5'd1, 5'd9, 5'd10, 1'b0, 32'h0000_0030);
        set_wb(1'b1, 5'd9, 32'hDEAD_BEEF);
        #1;
`ifdef OPFETCH_WB_BYPASS_EN
        check("wb_bypass_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
`else
        check("wb_detect_ready", 32'(bus.w_in_ready), 32'd0);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        check("wb_wait_ready", 32'(bus.w_in_ready), 32'd0);
        tick();
        #1;
        check("wb_resume_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        exp_stall = exp_stall + 16'd2;
`endif
        check("wb_valid", 32'(bus.w_out_valid), 32'd1);
        check("wb_s2val", bus.w_out_s2val_32, 32'hDEAD_BEEF);
        check("wb_stall", 32'(bus.w_stall_count_16), 32'(exp_stall));
        idle();
        tick();

        // Register 0 ignores writeback and register-file contents
        issue(5'd0, 5'd5, 5'd11, 1'b0, 32'h0000_0040);
        set_wb(1'b1, 5'd0, 32'h0000_1234);
        #1;
        check("r0_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        check("r0_s1val", bus.w_out_s1val_32, 32'd0);
        check("r0_stall", 32'(bus.w_stall_count_16), 32'(exp_stall));
        // Back-to-back: transfer in and out together keeps valid high
        issue(5'd0, 5'd0, 5'd12, 1'b0, 32'h0000_0041);
        #1;
        check("b2b_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        check("b2b_valid", 32'(bus.w_out_valid), 32'd1);
        check("b2b_d", 32'(bus.w_out_address_d_5), 32'd12);
        check("b2b_s2val", bus.w_out_s2val_32, 32'd0);
        idle();
        tick();

        // Backpressure for three cycles
        bus.w_out_ready = 1'b0;
        issue(5'd3, 5'd4, 5'd13, 1'b0, 32'hFFFF_FFF0);
        #1;
        tick();
        issue(5'd5, 5'd6, 5'd14, 1'b0, 32'h0000_0050);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready", 32'(bus.w_in_ready), 32'd0);
            tick();
            check("bp_hold_d", 32'(bus.w_out_address_d_5), 32'd13);
            check("bp_hold_s1val", bus.w_out_s1val_32, 32'd3);
        end
        exp_stall = exp_stall + 16'd3;
        check("bp_stall", 32'(bus.w_stall_count_16), 32'(exp_stall));
        bus.w_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        check("bp_replace_valid", 32'(bus.w_out_valid), 32'd1);
        check("bp_replace_d", 32'(bus.w_out_address_d_5), 32'd14);
        idle();
        tick();

        // Reset asserted during LOAD_BUBBLE
        issue(5'd1, 5'd2, 5'd15, 1'b1, 32'h0000_0060);
        #1;
        tick();
        issue(5'd15, 5'd0, 5'd16, 1'b0, 32'h0000_0061);
        #1;
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.w_out_valid), 32'd0);
        check("mid_rst_stall", 32'(bus.w_stall_count_16), 32'd0);
        check("mid_rst_ready", 32'(bus.w_in_ready), 32'd0);
        check("mid_rst_d", 32'(bus.w_out_address_d_5), 32'd0);
        sb.delete();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.w_in_ready), 32'd1);
        tick();
        check("post_rst_valid", 32'(bus.w_out_valid), 32'd1);
        check("post_rst_d", 32'(bus.w_out_address_d_5), 32'd16);
        check("post_rst_stall", 32'(bus.w_stall_count_16), 32'd0);
        idle();
        tick();

        // Reset while a bundle is held, then stall counter saturation
        bus.w_out_ready = 1'b0;
        issue(5'd7, 5'd8, 5'd17, 1'b1, 32'h0000_0070);
        #1;
        tick();
        check("hold_valid", 32'(bus.w_out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("hold_rst_valid", 32'(bus.w_out_valid), 32'd0);
        check("hold_rst_s1val", bus.w_out_s1val_32, 32'd0);
        check("hold_rst_imm", bus.w_out_imm_32, 32'd0);
        check("hold_rst_is_load", 32'(bus.w_out_is_load), 32'd0);
        sb.delete();
        reset = 1'b0;
        #1;
        tick();
        for (int k = 0; k < 65534; k++) tick();
        check("sat_fffe", 32'(bus.w_stall_count_16), 32'h0000_FFFE);
        tick();
        check("sat_ffff", 32'(bus.w_stall_count_16), 32'h0000_FFFF);
        for (int k = 0; k < 3; k++) tick();
        check("sat_hold", 32'(bus.w_stall_count_16), 32'h0000_FFFF);
        bus.w_out_ready = 1'b1;
        idle();
        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
